// File: rtl/tcp_msg_req_store.sv
// Per-flow message-request store: one outstanding request per flow, written by the
// app side and read (optionally consumed) by the TCP message poller.
module tcp_msg_req_store #(
    parameter int unsigned FLOWID_W  = 8,
    parameter int unsigned REQ_PTR_W = 16,
    parameter int unsigned XY_W      = 8,
    parameter int unsigned FBITS_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  wr_req_val,
    input  logic [FLOWID_W-1:0]   wr_req_flowid,
    input  logic [REQ_PTR_W-1:0]  wr_req_length,
    input  logic [XY_W-1:0]       wr_req_dst_x,
    input  logic [XY_W-1:0]       wr_req_dst_y,
    input  logic [FBITS_W-1:0]    wr_req_dst_fbits,
    output logic                  wr_req_rdy,
    output logic                  wr_resp_val,
    output logic                  wr_resp_ok,
    input  logic                  wr_resp_rdy,

    input  logic                  poll_req_val,
    input  logic [FLOWID_W-1:0]   poll_req_flowid,
    input  logic                  poll_req_clear,
    output logic                  poll_req_rdy,
    output logic                  poll_resp_val,
    output logic [FLOWID_W-1:0]   poll_resp_flowid,
    output logic                  poll_resp_pending,
    output logic [REQ_PTR_W-1:0]  poll_resp_length,
    output logic [XY_W-1:0]       poll_resp_dst_x,
    output logic [XY_W-1:0]       poll_resp_dst_y,
    output logic [FBITS_W-1:0]    poll_resp_dst_fbits,
    input  logic                  poll_resp_rdy,

    output logic [FLOWID_W:0]     pending_count
);

    localparam int unsigned DEPTH = 1 << FLOWID_W;
    localparam int unsigned CNT_W = FLOWID_W + 1;

    typedef struct packed {
        logic [REQ_PTR_W-1:0] length;
        logic [XY_W-1:0]      dst_x;
        logic [XY_W-1:0]      dst_y;
        logic [FBITS_W-1:0]   dst_fbits;
    } payload_t;

    logic [DEPTH-1:0]    bitmap_q, bitmap_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    payload_t            mem_q [DEPTH];
    payload_t            ram_rd_q;
    payload_t            wr_payload;

    logic                wr_resp_val_q, wr_resp_ok_q;
    logic                s1_val_q, s1_pend_q;
    logic [FLOWID_W-1:0] s1_flowid_q;
    logic                poll_val_q, poll_pend_q;
    logic [FLOWID_W-1:0] poll_flowid_q;
    payload_t            poll_data_q;

    logic wr_acc, wr_set, poll_acc, poll_hit, poll_clr;

    assign wr_req_rdy   = !wr_resp_val_q || wr_resp_rdy;
    assign poll_req_rdy = !s1_val_q && (!poll_val_q || poll_resp_rdy);

    // Both paths see the start-of-cycle bitmap; no forwarding between them.
    assign wr_acc   = wr_req_val && wr_req_rdy;
    assign wr_set   = wr_acc && !bitmap_q[wr_req_flowid];
    assign poll_acc = poll_req_val && poll_req_rdy;
    assign poll_hit = bitmap_q[poll_req_flowid];
    assign poll_clr = poll_acc && poll_req_clear && poll_hit;

    assign wr_payload = '{length: wr_req_length, dst_x: wr_req_dst_x,
                          dst_y: wr_req_dst_y, dst_fbits: wr_req_dst_fbits};

    always_comb begin
        bitmap_d = bitmap_q;
        cnt_d    = cnt_q;
        if (poll_clr) bitmap_d[poll_req_flowid] = 1'b0;
        if (wr_set)   bitmap_d[wr_req_flowid]   = 1'b1;
        if (wr_set && !poll_clr)      cnt_d = cnt_q + CNT_W'(1);
        else if (!wr_set && poll_clr) cnt_d = cnt_q - CNT_W'(1);
    end

    // Payload RAM: 1R/1W, read-first, contents not reset.
    always_ff @(posedge clk) begin
        if (wr_set)   mem_q[wr_req_flowid] <= wr_payload;
        if (poll_acc) ram_rd_q <= mem_q[poll_req_flowid];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bitmap_q      <= '0;
            cnt_q         <= '0;
            wr_resp_val_q <= 1'b0;
            wr_resp_ok_q  <= 1'b0;
            s1_val_q      <= 1'b0;
            s1_pend_q     <= 1'b0;
            s1_flowid_q   <= '0;
            poll_val_q    <= 1'b0;
            poll_pend_q   <= 1'b0;
            poll_flowid_q <= '0;
            poll_data_q   <= '0;
        end else begin
            bitmap_q <= bitmap_d;
            cnt_q    <= cnt_d;

            if (wr_acc) begin
                wr_resp_val_q <= 1'b1;
                wr_resp_ok_q  <= wr_set;
            end else if (wr_resp_rdy) begin
                wr_resp_val_q <= 1'b0;
            end

            s1_val_q <= poll_acc;
            if (poll_acc) begin
                s1_pend_q   <= poll_hit;
                s1_flowid_q <= poll_req_flowid;
            end

            // Stage 1 only exists when the output register is free.
            if (s1_val_q) begin
                poll_val_q    <= 1'b1;
                poll_pend_q   <= s1_pend_q;
                poll_flowid_q <= s1_flowid_q;
                poll_data_q   <= s1_pend_q ? ram_rd_q : '0;
            end else if (poll_resp_rdy) begin
                poll_val_q <= 1'b0;
            end
        end
    end

    assign wr_resp_val         = wr_resp_val_q;
    assign wr_resp_ok          = wr_resp_ok_q;
    assign poll_resp_val       = poll_val_q;
    assign poll_resp_flowid    = poll_flowid_q;
    assign poll_resp_pending   = poll_pend_q;
    assign poll_resp_length    = poll_data_q.length;
    assign poll_resp_dst_x     = poll_data_q.dst_x;
    assign poll_resp_dst_y     = poll_data_q.dst_y;
    assign poll_resp_dst_fbits = poll_data_q.dst_fbits;
    assign pending_count       = cnt_q;

endmodule

// File: tb/tb_tcp_msg_req_store.sv
// Scoreboard bench for tcp_msg_req_store: a per-flow array model predicts write and
// poll results at accept time; a negedge monitor compares what the DUT presents.
module tb_tcp_msg_req_store;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_req_val;
    logic [7:0]  wr_req_flowid;
    logic [15:0] wr_req_length;
    logic [7:0]  wr_req_dst_x, wr_req_dst_y;
    logic [3:0]  wr_req_dst_fbits;
    logic        wr_req_rdy, wr_resp_val, wr_resp_ok, wr_resp_rdy;
    logic        poll_req_val, poll_req_clear, poll_req_rdy;
    logic [7:0]  poll_req_flowid;
    logic        poll_resp_val, poll_resp_pending, poll_resp_rdy;
    logic [7:0]  poll_resp_flowid;
    logic [15:0] poll_resp_length;
    logic [7:0]  poll_resp_dst_x, poll_resp_dst_y;
    logic [3:0]  poll_resp_dst_fbits;
    logic [8:0]  pending_count;

    tcp_msg_req_store dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req_val(wr_req_val), .wr_req_flowid(wr_req_flowid),
        .wr_req_length(wr_req_length), .wr_req_dst_x(wr_req_dst_x),
        .wr_req_dst_y(wr_req_dst_y), .wr_req_dst_fbits(wr_req_dst_fbits),
        .wr_req_rdy(wr_req_rdy), .wr_resp_val(wr_resp_val), .wr_resp_ok(wr_resp_ok),
        .wr_resp_rdy(wr_resp_rdy),
        .poll_req_val(poll_req_val), .poll_req_flowid(poll_req_flowid),
        .poll_req_clear(poll_req_clear), .poll_req_rdy(poll_req_rdy),
        .poll_resp_val(poll_resp_val), .poll_resp_flowid(poll_resp_flowid),
        .poll_resp_pending(poll_resp_pending), .poll_resp_length(poll_resp_length),
        .poll_resp_dst_x(poll_resp_dst_x), .poll_resp_dst_y(poll_resp_dst_y),
        .poll_resp_dst_fbits(poll_resp_dst_fbits), .poll_resp_rdy(poll_resp_rdy),
        .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int flowid;
        int pend;
        int len;
        int x;
        int y;
        int fb;
        int acc;
    } pexp_t;

    int    wexp_q[$];
    pexp_t pexp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    exp_prdy = -1;

    // Reference model: what each flow currently holds and how many are pending.
    int m_pend[256];
    int m_len[256], m_x[256], m_y[256], m_fb[256];
    int m_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: model the handshakes seen this cycle, then advance past the edge.
    task automatic step();
        int wh, ph, wf, pf;
        pexp_t e;
        @(negedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) m_pend[i] = 0;
            m_cnt = 0;
            wexp_q.delete();
            pexp_q.delete();
        end else begin
            chk("pending_count", 64'(pending_count), 64'(m_cnt));
            if (exp_prdy >= 0) chk("poll_req_rdy", 64'(poll_req_rdy), 64'(exp_prdy));
            wf = int'(wr_req_flowid);
            pf = int'(poll_req_flowid);
            wh = m_pend[wf];
            ph = m_pend[pf];
            if (poll_req_val && poll_req_rdy) begin
                e.flowid = pf; e.pend = ph; e.acc = cyc;
                e.len = ph ? m_len[pf] : 0;
                e.x   = ph ? m_x[pf]   : 0;
                e.y   = ph ? m_y[pf]   : 0;
                e.fb  = ph ? m_fb[pf]  : 0;
                pexp_q.push_back(e);
                if (poll_req_clear && ph != 0) begin
                    m_pend[pf] = 0;
                    m_cnt--;
                end
            end
            if (wr_req_val && wr_req_rdy) begin
                wexp_q.push_back(wh == 0 ? 1 : 0);
                if (wh == 0) begin
                    m_pend[wf] = 1;
                    m_len[wf] = int'(wr_req_length);
                    m_x[wf] = int'(wr_req_dst_x);
                    m_y[wf] = int'(wr_req_dst_y);
                    m_fb[wf] = int'(wr_req_dst_fbits);
                    m_cnt++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a result.
    logic        hold_prev = 1'b0;
    logic [47:0] held;
    always @(negedge clk) begin
        pexp_t e;
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (wr_resp_val && wr_resp_rdy) begin
                if (wexp_q.size() == 0) chk("wr_resp_unexpected", 64'(1), 64'(0));
                else chk("wr_resp_ok", 64'(wr_resp_ok), 64'(wexp_q.pop_front()));
            end
            if (poll_resp_val) begin
                if (hold_prev) begin
                    chk("poll_resp_stable",
                        {16'h0, poll_resp_flowid, poll_resp_pending, 3'b0, poll_resp_length,
                         poll_resp_dst_x, poll_resp_dst_y, poll_resp_dst_fbits}, {16'h0, held});
                end else if (pexp_q.size() == 0) begin
                    chk("poll_resp_unexpected", 64'(1), 64'(0));
                end else begin
                    e = pexp_q[0];
                    chk("poll_latency", 64'(cyc), 64'(e.acc + 2));
                    chk("poll_flowid", 64'(poll_resp_flowid), 64'(e.flowid));
                    chk("poll_pending", 64'(poll_resp_pending), 64'(e.pend));
                    chk("poll_length", 64'(poll_resp_length), 64'(e.len));
                    chk("poll_dst_x", 64'(poll_resp_dst_x), 64'(e.x));
                    chk("poll_dst_y", 64'(poll_resp_dst_y), 64'(e.y));
                    chk("poll_fbits", 64'(poll_resp_dst_fbits), 64'(e.fb));
                end
                held = {poll_resp_flowid, poll_resp_pending, 3'b0, poll_resp_length,
                        poll_resp_dst_x, poll_resp_dst_y, poll_resp_dst_fbits};
                if (poll_resp_rdy) begin
                    if (!hold_prev || pexp_q.size() != 0) void'(pexp_q.pop_front());
                    hold_prev = 1'b0;
                end else begin
                    hold_prev = 1'b1;
                end
            end
        end
    end

    task automatic do_wr(input int f, input int len, input int x, input int y, input int fb);
        wr_req_val = 1'b1; wr_req_flowid = 8'(f); wr_req_length = 16'(len);
        wr_req_dst_x = 8'(x); wr_req_dst_y = 8'(y); wr_req_dst_fbits = 4'(fb);
        step();
        wr_req_val = 1'b0;
    endtask

    task automatic do_poll(input int f, input bit clr);
        poll_req_val = 1'b1; poll_req_flowid = 8'(f); poll_req_clear = clr;
        step();
        poll_req_val = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic int pick_flow();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7) return int'($urandom_range(0, 7));
        if (r == 7) return 255;
        return int'($urandom_range(0, 255));
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) m_pend[i] = 0;
        rst_n = 1'b0;
        wr_req_val = 1'b0; wr_req_flowid = '0; wr_req_length = '0;
        wr_req_dst_x = '0; wr_req_dst_y = '0; wr_req_dst_fbits = '0;
        wr_resp_rdy = 1'b1; poll_resp_rdy = 1'b1;
        poll_req_val = 1'b0; poll_req_flowid = '0; poll_req_clear = 1'b0;
        @(posedge clk); #1;
        step();
        rst_n = 1'b1;
        chk("rst_wr_resp_val", 64'(wr_resp_val), 64'(0));
        chk("rst_poll_resp_val", 64'(poll_resp_val), 64'(0));
        chk("rst_pending_count", 64'(pending_count), 64'(0));

        // Empty poll, then write/poll-clear, then re-poll.
        do_poll(5, 1'b0); idle(3);
        do_wr(5, 16'h0400, 2, 1, 4'h3);
        do_poll(5, 1'b1); idle(3);
        do_poll(5, 1'b0); idle(3);

        // Double write without a poll.
        do_wr(7, 16'h0111, 3, 4, 5);
        do_wr(7, 16'h0222, 6, 7, 8);
        do_poll(7, 1'b0); idle(3);

        // Same-cycle write (rejected) and poll-clear on a pending flow.
        do_wr(9, 16'h0010, 1, 1, 1); idle(1);
        wr_req_val = 1'b1; wr_req_flowid = 8'd9; wr_req_length = 16'h0020;
        poll_req_val = 1'b1; poll_req_flowid = 8'd9; poll_req_clear = 1'b1;
        step();
        wr_req_val = 1'b0; poll_req_val = 1'b0;
        idle(3);
        do_poll(9, 1'b0); idle(3);

        // Output back-pressure: poll_req_rdy must stay low while the result is held.
        poll_resp_rdy = 1'b0;
        do_poll(7, 1'b0); idle(2);
        exp_prdy = 0;
        poll_req_val = 1'b1; poll_req_flowid = 8'd5; poll_req_clear = 1'b0;
        idle(5);
        poll_resp_rdy = 1'b1; exp_prdy = 1;
        step();
        exp_prdy = -1; poll_req_val = 1'b0;
        idle(3);

        // Fill every flow, then reset while a poll is in flight.
        for (int f = 0; f < 256; f++)
            do_wr(f, int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
        idle(1);
        do_poll(255, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_pending_count", 64'(pending_count), 64'(0));
        chk("midrst_poll_resp_val", 64'(poll_resp_val), 64'(0));
        chk("midrst_wr_resp_val", 64'(wr_resp_val), 64'(0));
        idle(3);
        do_poll(0, 1'b0); idle(3);
        do_poll(255, 1'b0); idle(3);
        do_poll(100, 1'b1); idle(3);

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 3000; i++) begin
            wr_req_val = 1'($urandom_range(0, 1));
            wr_req_flowid = 8'(pick_flow());
            wr_req_length = 16'($urandom_range(0, 65535));
            wr_req_dst_x = 8'($urandom_range(0, 255));
            wr_req_dst_y = 8'($urandom_range(0, 255));
            wr_req_dst_fbits = 4'($urandom_range(0, 15));
            poll_req_val = 1'($urandom_range(0, 1));
            poll_req_flowid = ($urandom_range(0, 3) == 0) ? wr_req_flowid : 8'(pick_flow());
            poll_req_clear = 1'($urandom_range(0, 1));
            wr_resp_rdy = ($urandom_range(0, 3) != 0);
            poll_resp_rdy = ($urandom_range(0, 3) != 0);
            step();
        end

        // Drain with a bounded wait.
        wr_req_val = 1'b0; poll_req_val = 1'b0;
        wr_resp_rdy = 1'b1; poll_resp_rdy = 1'b1;
        for (int i = 0; i < 20 && (wexp_q.size() != 0 || pexp_q.size() != 0); i++) step();
        chk("drain_wr_outstanding", 64'(wexp_q.size()), 64'(0));
        chk("drain_poll_outstanding", 64'(pexp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
